// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction memory boot loader: state encoding, counters
// and the instruction address/data buses.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LdIdle,
        LdHdrLo,
        LdHdrHi,
        LdData,
        LdCsum,
        LdDone,
        LdErr
    } ld_state_e;

    typedef logic [15:0] ld_cnt_t;
    typedef logic [31:0] instr_addr_t;
    typedef logic [31:0] instr_t;

    // Byte address of a word index: zero-extended and shifted left by 2.
    function automatic instr_addr_t word_addr(input ld_cnt_t idx);
        return {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: parses a framed byte stream and writes little-endian words into
// the instruction memory, holding the core in reset until a checksummed frame lands.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk_i_Loader,
    input  logic        rst_i_Loader,
    input  logic        start_i_Loader,
    input  logic [7:0]  byte_i_Loader,
    input  logic        byte_valid_i_Loader,
    output logic        byte_ready_o_Loader,
    output logic        mem_wr_en_o_Loader,
    output instr_addr_t mem_wr_addr_o_Loader,
    output instr_t      mem_wr_data_o_Loader,
    output logic        core_rst_o_Loader,
    output logic        busy_o_Loader,
    output logic        done_o_Loader,
    output logic        err_o_Loader
);

    ld_state_e  state;
    ld_cnt_t    word_cnt;
    ld_cnt_t    word_idx;
    logic [1:0] byte_idx;
    logic [7:0] sum;
    logic [7:0] hdr_lo;
    instr_t     word;
    logic       xfer;
    ld_cnt_t    hdr_n;

    // Ready depends on the state register alone, never on valid.
    assign byte_ready_o_Loader = (state == LdHdrLo) || (state == LdHdrHi) ||
                                 (state == LdData)  || (state == LdCsum);
    assign busy_o_Loader       = byte_ready_o_Loader;
    assign xfer                = byte_valid_i_Loader && byte_ready_o_Loader;
    assign hdr_n               = {byte_i_Loader, hdr_lo};

    always_ff @(posedge clk_i_Loader or posedge rst_i_Loader) begin
        if (rst_i_Loader) begin
            state                <= LdIdle;
            word_cnt             <= '0;
            word_idx             <= '0;
            byte_idx             <= '0;
            sum                  <= '0;
            hdr_lo               <= '0;
            word                 <= '0;
            mem_wr_en_o_Loader   <= 1'b0;
            mem_wr_addr_o_Loader <= '0;
            mem_wr_data_o_Loader <= '0;
            core_rst_o_Loader    <= 1'b1;
            done_o_Loader        <= 1'b0;
            err_o_Loader         <= 1'b0;
        end else begin
            mem_wr_en_o_Loader <= 1'b0;
            unique case (state)
                LdIdle: begin
                    if (start_i_Loader) state <= LdHdrLo;
                end
                LdHdrLo: begin
                    if (xfer) begin
                        hdr_lo <= byte_i_Loader;
                        state  <= LdHdrHi;
                    end
                end
                LdHdrHi: begin
                    if (xfer) begin
                        word_cnt <= hdr_n;
                        word_idx <= '0;
                        byte_idx <= '0;
                        // Cleared for every header so an empty frame checks against zero.
                        sum      <= '0;
                        if (32'(hdr_n) > MAX_WORDS) begin
                            state        <= LdErr;
                            err_o_Loader <= 1'b1;
                        end else if (hdr_n == '0) begin
                            state <= LdCsum;
                        end else begin
                            state <= LdData;
                        end
                    end
                end
                LdData: begin
                    if (xfer) begin
                        sum                         <= sum + byte_i_Loader;
                        word[{byte_idx, 3'b000} +: 8] <= byte_i_Loader;
                        byte_idx                    <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_wr_en_o_Loader   <= 1'b1;
                            mem_wr_addr_o_Loader <= word_addr(word_idx);
                            mem_wr_data_o_Loader <= {byte_i_Loader, word[23:0]};
                            word_idx             <= word_idx + 16'd1;
                            if (word_idx + 16'd1 == word_cnt) state <= LdCsum;
                        end
                    end
                end
                LdCsum: begin
                    if (xfer) begin
                        if (byte_i_Loader == sum) begin
                            state             <= LdDone;
                            done_o_Loader     <= 1'b1;
                            core_rst_o_Loader <= 1'b0;
                        end else begin
                            state        <= LdErr;
                            err_o_Loader <= 1'b1;
                        end
                    end
                end
                LdDone, LdErr: begin
                    if (start_i_Loader) begin
                        state             <= LdHdrLo;
                        done_o_Loader     <= 1'b0;
                        err_o_Loader      <= 1'b0;
                        core_rst_o_Loader <= 1'b1;
                    end
                end
                default: state <= LdIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: frames, checksum errors, oversize
// headers, stalls, back-to-back writes and mid-frame reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_d;
    logic        valid;
    logic        ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wide     = 0;
    logic prev_en = 1'b0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];

    imem_loader #(.MAX_WORDS(1024)) dut (
        .clk_i_Loader         (clk),
        .rst_i_Loader         (rst),
        .start_i_Loader       (start),
        .byte_i_Loader        (byte_d),
        .byte_valid_i_Loader  (valid),
        .byte_ready_o_Loader  (ready),
        .mem_wr_en_o_Loader   (wr_en),
        .mem_wr_addr_o_Loader (wr_addr),
        .mem_wr_data_o_Loader (wr_data),
        .core_rst_o_Loader    (core_rst),
        .busy_o_Loader        (busy),
        .done_o_Loader        (done),
        .err_o_Loader         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port recorder: address, data and cycle of every strobe, plus wide pulses.
    always @(negedge clk) begin
        if (wr_en) begin
            if (prev_en) wide++;
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            wc.push_back(cyc);
        end
        prev_en = wr_en;
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
        wide = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_d = b;
        valid  = 1'b1;
        while (!ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (!ready) begin
            $display("FAIL send_byte: ready stayed 0 for byte %02h, required 1", b);
            n_fail++;
        end else begin
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    // Bytes are listed most-significant first in v, so literals read in stream order.
    task automatic send_vec(input logic [127:0] v, input int n, input bit gapped);
        for (int i = 0; i < n; i++) begin
            if (gapped) begin
                for (int g = 0; g < i % 3; g++) begin
                    if (i == 5 && g == 0) start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            send_byte(v[8*(n-1-i) +: 8]);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++;
        if ({ready, wr_en, wr_addr, wr_data, core_rst, busy, done, err} !==
            {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL reset_values: ready=%b en=%b addr=%h data=%h crst=%b busy=%b done=%b err=%b",
                     ready, wr_en, wr_addr, wr_data, core_rst, busy, done, err);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({ready, busy, core_rst} !== 3'b001) begin
            $display("FAIL idle_after_reset: ready=%b busy=%b crst=%b, required 0 0 1",
                     ready, busy, core_rst);
            n_fail++;
        end
    endtask

    task automatic test_single_word();
        clear_log();
        pulse_start();
        n_checks++;
        if ({ready, busy} !== 2'b11) begin
            $display("FAIL start_ready: ready=%b busy=%b, required 1 1", ready, busy);
            n_fail++;
        end
        send_vec(128'h01_00_13_05_A0_00_B8, 7, 1'b0);
        n_checks++;
        if (wa.size() != 1 || wa[0] !== 32'h0 || wd[0] !== 32'h00A00513) begin
            $display("FAIL single_write: writes=%0d addr=%h data=%h, required 1 0 00a00513",
                     wa.size(), (wa.size() > 0) ? wa[0] : 32'hx, (wd.size() > 0) ? wd[0] : 32'hx);
            n_fail++;
        end
        n_checks++;
        if ({done, core_rst, err, busy} !== 4'b1000) begin
            $display("FAIL single_done: done=%b crst=%b err=%b busy=%b, required 1 0 0 0",
                     done, core_rst, err, busy);
            n_fail++;
        end
    endtask

    task automatic test_bad_csum();
        clear_log();
        pulse_start();
        n_checks++;
        if ({core_rst, done} !== 2'b10) begin
            $display("FAIL restart_from_done: crst=%b done=%b, required 1 0", core_rst, done);
            n_fail++;
        end
        send_vec(128'h01_00_13_05_A0_00_B9, 7, 1'b0);
        n_checks++;
        if (wa.size() != 1 || wd[0] !== 32'h00A00513) begin
            $display("FAIL bad_csum_write: writes=%0d, required 1 with data 00a00513", wa.size());
            n_fail++;
        end
        n_checks++;
        if ({err, core_rst, done} !== 3'b110) begin
            $display("FAIL bad_csum_flags: err=%b crst=%b done=%b, required 1 1 0",
                     err, core_rst, done);
            n_fail++;
        end
    endtask

    task automatic test_empty_frame();
        clear_log();
        pulse_start();
        n_checks++;
        if (err !== 1'b0) begin
            $display("FAIL restart_from_err: err=%b, required 0", err);
            n_fail++;
        end
        send_vec(128'h00_00_00, 3, 1'b0);
        n_checks++;
        if (wa.size() != 0 || {done, core_rst, err} !== 3'b100) begin
            $display("FAIL empty_frame: writes=%0d done=%b crst=%b err=%b, required 0 1 0 0",
                     wa.size(), done, core_rst, err);
            n_fail++;
        end
    endtask

    task automatic test_oversize();
        clear_log();
        pulse_start();
        send_vec(128'h01_04, 2, 1'b0);
        n_checks++;
        if ({err, ready, busy, core_rst, done} !== 5'b10010 || wa.size() != 0) begin
            $display("FAIL oversize: err=%b ready=%b busy=%b crst=%b done=%b writes=%0d",
                     err, ready, busy, core_rst, done, wa.size());
            n_fail++;
        end
    endtask

    task automatic test_gapped_three();
        clear_log();
        pulse_start();
        send_vec(128'h03_00_44_33_22_11_EF_BE_AD_DE_01_00_00_00_E3, 15, 1'b1);
        n_checks++;
        if (wa.size() != 3) begin
            $display("FAIL gapped_count: writes=%0d, required 3", wa.size());
            n_fail++;
        end else begin
            n_checks++;
            if (wa[0] !== 32'h0 || wa[1] !== 32'h4 || wa[2] !== 32'h8) begin
                $display("FAIL gapped_addr: %h %h %h, required 0 4 8", wa[0], wa[1], wa[2]);
                n_fail++;
            end
            n_checks++;
            if (wd[0] !== 32'h11223344 || wd[1] !== 32'hDEADBEEF || wd[2] !== 32'h00000001) begin
                $display("FAIL gapped_data: %h %h %h, required 11223344 deadbeef 00000001",
                         wd[0], wd[1], wd[2]);
                n_fail++;
            end
        end
        n_checks++;
        if (wide != 0 || {done, core_rst, err} !== 3'b100) begin
            $display("FAIL gapped_end: wide=%0d done=%b crst=%b err=%b, required 0 1 0 0",
                     wide, done, core_rst, err);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        pulse_start();
        send_vec(128'h02_00_78_56_34_12_00_00_00_80_94, 11, 1'b0);
        n_checks++;
        if (wa.size() != 2 || wc[1] - wc[0] != 4 || wd[0] !== 32'h12345678 ||
            wd[1] !== 32'h80000000 || wa[1] !== 32'h4) begin
            $display("FAIL back_to_back: writes=%0d spacing=%0d, required 2 writes 4 cycles apart",
                     wa.size(), (wc.size() > 1) ? wc[1] - wc[0] : -1);
            n_fail++;
        end
        n_checks++;
        if ({done, core_rst} !== 2'b10) begin
            $display("FAIL back_to_back_done: done=%b crst=%b, required 1 0", done, core_rst);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        pulse_start();
        send_vec(128'h02_00_11_22_33_44_55_66, 8, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ready, wr_en, wr_addr, wr_data, core_rst, busy, done, err} !==
            {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL mid_reset_values: ready=%b en=%b addr=%h data=%h crst=%b busy=%b",
                     ready, wr_en, wr_addr, wr_data, core_rst, busy);
            n_fail++;
        end
        n_checks++;
        if (wa.size() != 1) begin
            $display("FAIL mid_reset_writes: writes=%0d, required 1", wa.size());
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        // A byte presented with start in IDLE must not be consumed.
        byte_d = 8'hFF;
        valid  = 1'b1;
        pulse_start();
        valid  = 1'b0;
        send_vec(128'h01_00_13_05_A0_00_B8, 7, 1'b0);
        n_checks++;
        if (wa.size() != 1 || wa[0] !== 32'h0 || wd[0] !== 32'h00A00513 ||
            {done, core_rst, err} !== 3'b100) begin
            $display("FAIL reload_after_reset: writes=%0d done=%b crst=%b err=%b",
                     wa.size(), done, core_rst, err);
            n_fail++;
        end
    endtask

    initial begin
        start  = 1'b0;
        valid  = 1'b0;
        byte_d = 8'h00;
        test_reset();
        test_single_word();
        test_bad_csum();
        test_empty_frame();
        test_oversize();
        test_gapped_three();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the core's instruction memory. Receives a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them sequentially into the instruction ROM's write port from byte address 0. Holds the core in reset until a complete frame with a matching checksum has been written. Sits beside `ROM_InstrMem`, on the write side, opposite the fetch path.

## Interface

- `MAX_WORDS`, default 1024: instruction memory depth in words. A frame header above this is rejected.
- `clk_i_Loader` in 1: clock.
- `rst_i_Loader` in 1: reset, asynchronous, active-high.
- `start_i_Loader` in 1: one-cycle pulse that begins a load session. Ignored while a frame is in progress.
- `byte_i_Loader` in 8: incoming stream byte.
- `byte_valid_i_Loader` in 1: `byte_i_Loader` is valid.
- `byte_ready_o_Loader` out 1: loader can accept a byte.
- `mem_wr_en_o_Loader` out 1: instruction memory write strobe, one cycle per word.
- `mem_wr_addr_o_Loader` out 32 (`InstrAddrBus`): byte address, always word-aligned.
- `mem_wr_data_o_Loader` out 32 (`InstrBus`): instruction word.
- `core_rst_o_Loader` out 1: reset to the core, active-high.
- `busy_o_Loader` out 1: a frame is in progress.
- `done_o_Loader` out 1: last frame loaded and checksum OK.
- `err_o_Loader` out 1: last frame aborted.

## Operation

- **Frame format:**
  - 2 header bytes: word count N, 16-bit, low byte first.
  - 4·N payload bytes; byte k of each word goes to bits [8k+7:8k].
  - 1 checksum byte: 8-bit wrapping sum of all payload bytes.
- **Transfer rule:** a byte transfers on a cycle where valid and ready are both high.
- **States:**
  - IDLE, HDR_LO, HDR_HI, DATA, CSUM, DONE, ERR.
  - `byte_ready_o_Loader` is high only in HDR_LO, HDR_HI, DATA and CSUM.
  - `byte_ready_o_Loader` is decoded from the state register only. There is no combinational path from valid to ready.
  - `busy_o_Loader` is high in the same four states.
- **State transitions:**
  - IDLE: `start_i_Loader` → HDR_LO.
  - HDR_LO: transfer → HDR_HI.
  - HDR_HI: transfer computes N.
    - N > `MAX_WORDS` → ERR.
    - N = 0 → CSUM.
    - Otherwise → DATA, with word index and byte index cleared and the running sum cleared.
  - DATA: each transfer adds the byte to the running sum.
    - On the 4th byte of a word, register the write: address = word index × 4, data = assembled word. Then increment the word index.
    - When the word index reaches N → CSUM.
  - CSUM: transfer compares the byte with the running sum. Equal → DONE, else → ERR.
  - DONE or ERR: `start_i_Loader` → HDR_LO.
- **Outputs in DONE and ERR:**
  - DONE: `done_o_Loader` = 1, `core_rst_o_Loader` = 0.
  - ERR: `err_o_Loader` = 1, `core_rst_o_Loader` = 1.
  - Leaving DONE or ERR clears both flags and drives `core_rst_o_Loader` to 1 in the same edge.
- **Arithmetic:** sum wraps mod 256. Word index is 16 bits. The address is the zero-extended index shifted left by 2.
- **Re-entry:** a second load overwrites from address 0. Words beyond the new N are left untouched.
- **Reset:** `rst_i_Loader` at any time, including mid-frame, forces every output to its reset value immediately. State returns to IDLE. A partial frame is abandoned; no completion write is issued.

## Timing

- **Reset values:**
  - `byte_ready_o_Loader` = 0, `mem_wr_en_o_Loader` = 0.
  - `mem_wr_addr_o_Loader` = 0, `mem_wr_data_o_Loader` = 0.
  - `core_rst_o_Loader` = 1.
  - `busy_o_Loader` = 0, `done_o_Loader` = 0, `err_o_Loader` = 0.
- **Start:** `byte_ready_o_Loader` rises the cycle after the `start_i_Loader` edge.
- **Write latency:** `mem_wr_en_o_Loader` is high for exactly one cycle, the cycle after the 4th byte of a word is accepted. Address and data are valid in that cycle and hold afterwards.
- **Throughput:** one byte per cycle with `byte_valid_i_Loader` held high. Back-to-back words produce one write every 4 cycles. Gaps in valid stall the loader with no side effects.
- **Release:** `core_rst_o_Loader` falls the cycle after the checksum byte is accepted, and only when the checksum matches.
- **Final word:** in the last word the write strobe precedes the checksum transfer, so the final word is written before the core leaves reset.
- **Simultaneous events:**
  - `start_i_Loader` together with a byte in IDLE: the byte is not accepted, because ready is 0.
  - `start_i_Loader` while busy: no effect.

## Structure

- Add to `define.v`:
  - loader state encodings `LdIdle`, `LdHdrLo`, `LdHdrHi`, `LdData`, `LdCsum`, `LdDone`, `LdErr` (3-bit);
  - `LdCntBus` [15:0].
- Reuse `InstrAddrBus` and `InstrBus`.
- Single module. Byte assembly is a 2-bit index plus a 32-bit shift/insert register inside it; no sub-module.
- Top level: `ROM_InstrMem` gains a write port driven by this block. `reset_i_core` of `rv32IRJCore` is driven from `core_rst_o_Loader`.

## Test plan

1. **Single word:** start, then bytes 01 00 13 05 A0 00 B8 → one write at address 0x0 with data 0x00A00513. Then done = 1, core_rst = 0, err = 0.
2. **Bad checksum:** same frame with checksum 0xB9 → the write still occurs, then err = 1, core_rst stays 1, done = 0.
3. **Empty frame:** start, 00 00 00 → no writes, done = 1, core_rst = 0.
4. **Oversize header:** `MAX_WORDS` = 1024, header 01 04 (N = 1025) → ERR right after HDR_HI, ready = 0, no writes.
5. **Three words with gaps:** valid toggled randomly → writes at 0x0, 0x4, 0x8 with the correct words. Each strobe is one cycle wide. Release follows a correct checksum.
6. **Reset mid-frame, then restart:**
   - Assert reset after 6 payload bytes → all outputs return to reset values immediately; a fresh frame then loads correctly.
   - Start from DONE → core_rst rises the next edge and done clears.
